// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared constants for the PDM generator / decimator pair
package pdm_pkg;

  // log2 of the integration window; 32 clocks matches the 5-bit generator
  localparam int PDM_WINDOW_LOG2 = 5;

  // one extra bit so the full-scale count 2^WINDOW_LOG2 fits
  localparam int PDM_SAMPLE_W = PDM_WINDOW_LOG2 + 1;

  // count produced by a window of all ones (also the generator full scale)
  localparam logic [PDM_SAMPLE_W-1:0] PDM_FULL_SCALE = PDM_SAMPLE_W'(1) << PDM_WINDOW_LOG2;

  // full-scale count for an arbitrary window size
  function automatic int pdm_full_scale(input int window_log2);
    return 1 << window_log2;
  endfunction

endpackage

// File: rtl/pdm_decimator_if.sv
// rtl/pdm_decimator_if.sv - PCM sample output bus with ready/ack handshake
interface pdm_decimator_if
  import pdm_pkg::*;
#(
  parameter int SAMPLE_W = PDM_SAMPLE_W
) ();

  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                ready;
  logic                overrun;
  logic                ack;

  // decimator side drives the sample and status, consumer returns ack
  modport master (
    output sample,
    output sample_valid,
    output ready,
    output overrun,
    input  ack
  );

  modport slave (
    input  sample,
    input  sample_valid,
    input  ready,
    input  overrun,
    output ack
  );

endinterface

// File: rtl/pdm_window_acc.sv
// rtl/pdm_window_acc.sv - window counter and ones accumulator for integrate-and-dump
module pdm_window_acc
  import pdm_pkg::*;
#(
  parameter int WINDOW_LOG2 = PDM_WINDOW_LOG2,
  parameter int SAMPLE_W    = WINDOW_LOG2 + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pdm_in,
  input  logic                en,
  input  logic                align,
  output logic                done,
  output logic [SAMPLE_W-1:0] count
);

  logic [WINDOW_LOG2-1:0] cnt;
  logic [SAMPLE_W-1:0]    acc;
  logic                   last;

  // final bit position of the window
  assign last  = (cnt == {WINDOW_LOG2{1'b1}});

  // align wins over en, so a bit clocked in with align never completes a window
  assign done  = en & ~align & last;

  // running total including the current bit; on the last bit this is the sample
  assign count = acc + SAMPLE_W'(pdm_in);

  // advance the window on qualified bits; align restarts it and drops the bit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (align) begin
      cnt <= '0;
      acc <= '0;
    end else if (en) begin
      cnt <= cnt + WINDOW_LOG2'(1);
      acc <= last ? '0 : count;
    end
  end

endmodule

// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - PDM to PCM integrate-and-dump decimator with ready/ack
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int WINDOW_LOG2 = PDM_WINDOW_LOG2,
  parameter int SAMPLE_W    = WINDOW_LOG2 + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic pdm_in,
  input  logic en,
  input  logic align,
  pdm_decimator_if.master bus
);

  logic                done;
  logic [SAMPLE_W-1:0] count;

  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;
  logic                ready_q;
  logic                overrun_q;

  pdm_window_acc #(
    .WINDOW_LOG2 (WINDOW_LOG2),
    .SAMPLE_W    (SAMPLE_W)
  ) u_window_acc (
    .clk    (clk),
    .reset  (reset),
    .pdm_in (pdm_in),
    .en     (en),
    .align  (align),
    .done   (done),
    .count  (count)
  );

  // capture the completed window; newest data always replaces an unread sample
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= done;
      if (done) begin
        sample_q <= count;
      end
    end
  end

  // ready sets on completion; a same-cycle ack cannot clear it
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else if (done) begin
      ready_q <= 1'b1;
    end else if (bus.ack) begin
      ready_q <= 1'b0;
    end
  end

  // overrun flags a completion landing on an unacknowledged sample; ack clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (bus.ack) begin
      overrun_q <= 1'b0;
    end else if (done && ready_q) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.ready        = ready_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Downstream consumer of the 1-bit PDM stream produced by the 5-bit PDM generator user module.
- Integrate-and-dump decimator: counts ones over a fixed window of 2^WINDOW_LOG2 clocks and emits a PCM sample equal to that count.
- Provides a pulse strobe, a level ready/ack handshake and a sticky overrun flag.
- Used as on-chip loopback checker and as a stand-alone PDM-to-PCM front end.

Parameters:
- WINDOW_LOG2, 5, log2 of window length in clocks; default 32 matches 5-bit generator resolution.
- SAMPLE_W, WINDOW_LOG2+1, sample width; must hold the full-scale count 2^WINDOW_LOG2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pdm_in  input  1  PDM bit; sampled only when en=1.
- en  input  1  bit-qualify; en=0 freezes window counter and accumulator.
- align  input  1  synchronous window restart; discards the partial window.
- ack  input  1  consumer acknowledge; clears ready and overrun.
- sample  output  SAMPLE_W  last completed window count, 0..2^WINDOW_LOG2.
- sample_valid  output  1  one-clock pulse when sample updates.
- ready  output  1  level; set on window completion, cleared by ack.
- overrun  output  1  sticky; a window completed while ready=1 without ack.

Behaviour:
- State: cnt (WINDOW_LOG2 bits), acc (SAMPLE_W bits), sample register, ready, overrun.
- Reset (synchronous, highest priority): cnt=0, acc=0, sample=0, sample_valid=0, ready=0, overrun=0. Reset mid-window discards the partial window with no output.
- Priority order: reset > align > en.
- align=1 sets cnt=0 and acc=0; the pdm_in bit in that cycle is discarded, even if en=1. align does not touch sample, ready or overrun.
- en=1, align=0, cnt<2^W-1: acc += pdm_in, cnt += 1.
- en=1, align=0, cnt==2^W-1 (last bit of window):
  - sample <= acc + pdm_in (full SAMPLE_W width; no saturation needed).
  - acc <= 0; cnt wraps to 0.
  - sample_valid=1 in the next cycle, for exactly one cycle.
- Latency: sample and sample_valid are visible the cycle after the final window bit is clocked in.
- en=0: cnt and acc hold; sample_valid=0.
- ready:
  - Set on window completion.
  - Cleared on ack=1 when no completion occurs in the same cycle.
  - Completion and ack in the same cycle: ready stays 1, overrun is not set.
- overrun:
  - Set when a completion occurs while ready=1 and ack=0.
  - Cleared by ack=1 (takes effect next cycle) or by reset.
  - sample is overwritten on overrun; the newest data always wins.
- ack while ready=0: no effect except clearing overrun.
- Boundaries:
  - All ones gives sample=2^W (32 = 6'b100000).
  - All zeros gives 0.
  - Windows with intermittent en count only qualified bits.

Decomposition:
- Shared package pdm_pkg:
  - PDM_WINDOW_LOG2 default = 5.
  - Derived PDM_SAMPLE_W.
  - Full-scale constant shared with the generator.
- One natural sub-module, pdm_window_acc: holds cnt/acc and produces the completion pulse plus the count.
- The top level adds the sample register, ready/ack logic and overrun logic.

Test Plan:
- reset pulsed for 1 clk; pdm_in=1, en=1 constant for 32 clk -> sample_valid pulses on clk 33; sample=32; ready=1.
- Drive the pdm generator output with value 8, window aligned to generator phase -> sample=8 each window; with 0x1a -> 26; with 0x0f -> 15.
- pdm_in=1 for 10 clk, then align=1 for 1 clk, then pdm_in=0 for 32 clk -> sample=0; no valid before the post-align window completes.
- Two windows of all ones with no ack -> second completion sets overrun=1, ready=1, sample=32; ack for 1 clk -> ready=0, overrun=0 next clk.
- ack asserted in the exact completion cycle -> ready stays 1, overrun stays 0.
- en toggled 1/0 each clk with pdm_in=1 -> completion after 64 clk, sample=32. Reset asserted at cnt=20 -> all outputs 0; next window counts from 0.
